// File: rtl/tmds_video_sequencer.sv
// rtl/tmds_video_sequencer.sv - video timing and TMDS encoder scheduler (optional colour bars: TEST_PATTERN_EN)
module tmds_video_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        pix_req,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        enc_en,
    output logic [7:0]  enc_data_r,
    output logic [7:0]  enc_data_g,
    output logic [7:0]  enc_data_b,
    output logic [1:0]  enc_ctrl_b,
    output logic [1:0]  enc_ctrl_g,
    output logic [1:0]  enc_ctrl_r,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic        frame_start,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic HS_ACT = HS_POL[0];
    localparam logic VS_ACT = VS_POL[0];

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t      state, state_nxt;
    logic [10:0] h;
    logic [9:0]  v;
    logic        running, h_last, v_last, active, hsync_on, vsync_on, miss;
    logic [23:0] pix_sel;

    assign running  = (state != IDLE);
    assign h_last   = (h == 11'(H_TOTAL - 1));
    assign v_last   = (v == 10'(V_TOTAL - 1));
    assign active   = running && (h < 11'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    assign hsync_on = running && (h >= 11'(H_ACTIVE + H_FP)) && (h < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_on = running && (v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC));

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [10:0] bar_idx;
    logic [2:0]  bar;

    // Bar index bits map straight onto colour: r=~bar[1], g=~bar[2], b=~bar[0].
    always_comb begin
        bar_idx = h / 11'(BAR_W);
        bar     = (bar_idx > 11'd7) ? 3'd7 : bar_idx[2:0];
        pix_req = active && !pattern_sel;
        if (pattern_sel)
            pix_sel = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        else
            pix_sel = pix_valid ? pix_data : 24'h000000;
    end
`else
    always_comb begin
        pix_req = active;
        pix_sel = pix_valid ? pix_data : 24'h000000;
    end
`endif

    assign miss        = pix_req && !pix_valid;
    assign frame_start = (state == RUN) && (h == 11'd0) && (v == 10'd0);
    assign pos_x       = h;
    assign pos_y       = v;
    assign enc_ctrl_g  = 2'b00;
    assign enc_ctrl_r  = 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = RUN;
            RUN:      if (!en) state_nxt = STOPPING;
            STOPPING: begin
                if (en)
                    state_nxt = RUN;
                else if (h_last && v_last)
                    state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            enc_en     <= 1'b0;
            enc_data_r <= '0;
            enc_data_g <= '0;
            enc_data_b <= '0;
            enc_ctrl_b <= {~VS_ACT, ~HS_ACT};
            underflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counters only advance while a frame is in flight; IDLE leaves them parked at 0.
            if (running) begin
                h <= h_last ? 11'd0 : h + 11'd1;
                if (h_last)
                    v <= v_last ? 10'd0 : v + 10'd1;
            end
            enc_en <= active;
            {enc_data_r, enc_data_g, enc_data_b} <= active ? pix_sel : 24'h000000;
            enc_ctrl_b <= {vsync_on ? VS_ACT : ~VS_ACT, hsync_on ? HS_ACT : ~HS_ACT};
            // A miss on the first pixel belongs to the new frame, so set wins over clear.
            underflow <= (underflow && !frame_start) || miss;
        end
    end
endmodule

// File: tb/tb_tmds_video_sequencer.sv
// tb/tb_tmds_video_sequencer.sv - scoreboard bench for tmds_video_sequencer (8x6 timing)
module tb_tmds_video_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        pix_req, pix_valid;
    logic [23:0] pix_data;
    logic        enc_en;
    logic [7:0]  enc_data_r, enc_data_g, enc_data_b;
    logic [1:0]  enc_ctrl_b, enc_ctrl_g, enc_ctrl_r;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic        frame_start, underflow;

    tmds_video_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
        .enc_en(enc_en), .enc_data_r(enc_data_r), .enc_data_g(enc_data_g), .enc_data_b(enc_data_b),
        .enc_ctrl_b(enc_ctrl_b), .enc_ctrl_g(enc_ctrl_g), .enc_ctrl_r(enc_ctrl_r),
        .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference timing: 8 clocks/line, 6 lines/frame, active 4x3, hsync h=5..6, vsync v=4.
    int          m_st = 0;
    int          m_h = 0;
    int          m_v = 0;
    logic        m_en_d = 1'b0, m_hs_d = 1'b1, m_vs_d = 1'b1, m_uf = 1'b0;
    logic        m_act, m_fs;
    logic        miss_en = 1'b0;
    logic [23:0] ramp = 24'h000001;
    int          cyc = 0;

    assign m_act     = (m_st != 0) && (m_h < 4) && (m_v < 3);
    assign m_fs      = (m_st == 1) && (m_h == 0) && (m_v == 0);
    assign pix_data  = ramp;
    assign pix_valid = !(miss_en && m_h == 2 && m_v == 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_act) ramp <= ramp + 24'h1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 0; m_h <= 0; m_v <= 0;
            m_en_d <= 1'b0; m_hs_d <= 1'b1; m_vs_d <= 1'b1; m_uf <= 1'b0;
        end else begin
            m_en_d <= m_act;
            m_hs_d <= !((m_st != 0) && m_h >= 5 && m_h < 7);
            m_vs_d <= !((m_st != 0) && m_v == 4);
            m_uf   <= (m_uf && !m_fs) || (m_act && !pix_valid);
            case (m_st)
                0: if (en) m_st <= 1;
                1: if (!en) m_st <= 2;
                default: if (en) m_st <= 1; else if (m_h == 7 && m_v == 5) m_st <= 0;
            endcase
            if (m_st != 0) begin
                if (m_h == 7) begin
                    m_h <= 0;
                    m_v <= (m_v == 5) ? 0 : m_v + 1;
                end else begin
                    m_h <= m_h + 1;
                end
            end
        end
    end

    logic [23:0] sb[$];
    logic [23:0] exp_px;
    logic        stats_on = 1'b0;
    int          last_fs = -1;
    int          en_cnt = 0, hs_low = 0, vs_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (enc_en) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    exp_px = sb.pop_front();
                    chk("enc_data", {8'h0, enc_data_r, enc_data_g, enc_data_b}, {8'h0, exp_px});
                end
            end else begin
                chk("data_zero_off", {8'h0, enc_data_r, enc_data_g, enc_data_b}, 32'h0);
            end
            chk("enc_en", 32'(enc_en), 32'(m_en_d));
            chk("ctrl_b", 32'(enc_ctrl_b), 32'({m_vs_d, m_hs_d}));
            chk("ctrl_gr", 32'({enc_ctrl_g, enc_ctrl_r}), 32'h0);
            chk("pos_x", 32'(pos_x), 32'(m_h));
            chk("pos_y", 32'(pos_y), 32'(m_v));
            chk("pix_req", 32'(pix_req), 32'(m_act));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("underflow", 32'(underflow), 32'(m_uf));
            if (m_act) sb.push_back(pix_valid ? pix_data : 24'h000000);

            if (frame_start) begin
                if (stats_on && last_fs >= 0) begin
                    chk("frame_period", 32'(cyc - last_fs), 32'd48);
                    chk("de_per_frame", 32'(en_cnt), 32'd12);
                    chk("hs_low_per_frame", 32'(hs_low), 32'd12);
                    chk("vs_low_per_frame", 32'(vs_low), 32'd8);
                end
                last_fs = cyc;
                en_cnt = 0; hs_low = 0; vs_low = 0;
            end
            if (enc_en) en_cnt++;
            if (!enc_ctrl_b[0]) hs_low++;
            if (!enc_ctrl_b[1]) vs_low++;
        end
    end

    task automatic wait_pos(input int h, input int v, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (m_h == h && m_v == v) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_en"}, 32'(enc_en), 32'd0);
        chk({name, "_data"}, {8'h0, enc_data_r, enc_data_g, enc_data_b}, 32'h0);
        chk({name, "_ctrl_b"}, 32'(enc_ctrl_b), 32'h3);
        chk({name, "_fs"}, 32'(frame_start), 32'd0);
        chk({name, "_uf"}, 32'(underflow), 32'd0);
        chk({name, "_pos"}, {11'h0, pos_y, pos_x}, 32'h0);
        chk({name, "_req"}, 32'(pix_req), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_reset_vals("reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_reset_vals("idle");

        // Start: frame_start one cycle after en is sampled.
        en = 1'b1;
        stats_on = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("fs_latency", 32'(frame_start), 32'd1);

        // Second frame: drop pixel (2,1) and watch underflow set then clear.
        wait_pos(0, 0, 60, "frame2");
        miss_en = 1'b1;
        wait_pos(3, 1, 60, "miss_pix");
        chk("uf_set", 32'(underflow), 32'd1);
        wait_pos(0, 2, 60, "after_miss");
        miss_en = 1'b0;
        wait_pos(0, 0, 60, "frame3");
        chk("uf_hold_at_fs", 32'(underflow), 32'd1);
        @(posedge clk); #1;
        chk("uf_clear", 32'(underflow), 32'd0);

        // Stop mid-frame: finish the frame, then park in IDLE.
        wait_pos(0, 1, 60, "stop_pt");
        en = 1'b0;
        stats_on = 1'b0;
        wait_pos(7, 5, 60, "stop_end");
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("stopped_pos", {11'h0, pos_y, pos_x}, 32'h0);
            chk("stopped_en", 32'(enc_en), 32'd0);
            @(posedge clk); #1;
        end

        // Drop and reassert en within a frame: timing must not break.
        en = 1'b1;
        last_fs = -1;
        stats_on = 1'b1;
        wait_pos(3, 2, 60, "gap_pt");
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        wait_pos(0, 0, 60, "gap_fs1");
        wait_pos(0, 0, 60, "gap_fs2");

        // Asynchronous reset in the middle of a line.
        wait_pos(2, 1, 60, "rst_pt");
        stats_on = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        sb.delete();
        @(posedge clk); #1;
        chk_reset_vals("rst_held");
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("restart_fs", 32'(frame_start), 32'd1);
        chk("restart_pos", {11'h0, pos_y, pos_x}, 32'h0);
        wait_pos(0, 0, 60, "final_frame");
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
